// File: rtl/gpu_fill_rect_stream.sv
// Rectangle fill rasteriser: clips two corner points against a clip window and
// streams LANES-wide pixel beats with colour over a valid/ready handshake.
module gpu_fill_rect_stream #(
   parameter int unsigned WIDTH_BITS  = 10,
   parameter int unsigned HEIGHT_BITS = 9,
   parameter int unsigned COLOR_BITS  = 24,
   parameter int unsigned LANES       = 4
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [WIDTH_BITS-1:0]  x1_i,
   input  logic [HEIGHT_BITS-1:0] y1_i,
   input  logic [WIDTH_BITS-1:0]  x2_i,
   input  logic [HEIGHT_BITS-1:0] y2_i,
   input  logic [COLOR_BITS-1:0]  color_i,
   input  logic [WIDTH_BITS-1:0]  clip_x0_i,
   input  logic [WIDTH_BITS-1:0]  clip_x1_i,
   input  logic [HEIGHT_BITS-1:0] clip_y0_i,
   input  logic [HEIGHT_BITS-1:0] clip_y1_i,
   input  logic                   ready_i,
   output logic                   valid_o,
   output logic [WIDTH_BITS-1:0]  x_o,
   output logic [HEIGHT_BITS-1:0] y_o,
   output logic [LANES-1:0]       lane_mask_o,
   output logic [COLOR_BITS-1:0]  color_o,
   output logic                   last_o,
   output logic                   busy_o,
   output logic                   done_o
);

   // One spare bit on the column counter keeps x+LANES from wrapping at the edge.
   localparam int unsigned XW = WIDTH_BITS + 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;
   state_t state_q, state_d;

   logic [WIDTH_BITS-1:0]  x1_q, x2_q, cx0_q, cx1_q;
   logic [HEIGHT_BITS-1:0] y1_q, y2_q, cy0_q, cy1_q;
   logic [COLOR_BITS-1:0]  color_q;
   logic [XW-1:0]          x_q, xlo_q, xhi_q;
   logic [HEIGHT_BITS-1:0] y_q, yhi_q;

   logic [WIDTH_BITS-1:0]  xmin_c, xmax_c, xlo_c, xhi_c;
   logic [HEIGHT_BITS-1:0] ymin_c, ymax_c, ylo_c, yhi_c;
   logic                   empty_c, row_end_c, last_c, xfer_c;

   // Corner ordering and clipping from the latched request
   always_comb begin
      xmin_c  = (x1_q < x2_q) ? x1_q : x2_q;
      xmax_c  = (x1_q < x2_q) ? x2_q : x1_q;
      ymin_c  = (y1_q < y2_q) ? y1_q : y2_q;
      ymax_c  = (y1_q < y2_q) ? y2_q : y1_q;
      xlo_c   = (xmin_c > cx0_q) ? xmin_c : cx0_q;
      xhi_c   = (xmax_c < cx1_q) ? xmax_c : cx1_q;
      ylo_c   = (ymin_c > cy0_q) ? ymin_c : cy0_q;
      yhi_c   = (ymax_c < cy1_q) ? ymax_c : cy1_q;
      empty_c = (xlo_c > xhi_c) || (ylo_c > yhi_c);
   end

   assign row_end_c = (x_q + XW'(LANES)) > xhi_q;
   assign last_c    = (y_q == yhi_q) && row_end_c;
   assign xfer_c    = (state_q == S_RUN) && ready_i;

   always_ff @(posedge clk) begin
      if (!n_rst) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_SETUP;
         S_SETUP: begin
            if (abort_i)      state_d = S_IDLE;
            else if (empty_c) state_d = S_DONE;
            else              state_d = S_RUN;
         end
         S_RUN: begin
            if (abort_i)              state_d = S_IDLE;
            else if (xfer_c && last_c) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request capture and raster walk
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         x1_q    <= '0;
         x2_q    <= '0;
         y1_q    <= '0;
         y2_q    <= '0;
         cx0_q   <= '0;
         cx1_q   <= '0;
         cy0_q   <= '0;
         cy1_q   <= '0;
         color_q <= '0;
         x_q     <= '0;
         xlo_q   <= '0;
         xhi_q   <= '0;
         y_q     <= '0;
         yhi_q   <= '0;
      end else begin
         if ((state_q == S_IDLE) && start_i) begin
            x1_q    <= x1_i;
            x2_q    <= x2_i;
            y1_q    <= y1_i;
            y2_q    <= y2_i;
            cx0_q   <= clip_x0_i;
            cx1_q   <= clip_x1_i;
            cy0_q   <= clip_y0_i;
            cy1_q   <= clip_y1_i;
            color_q <= color_i;
         end
         if (state_q == S_SETUP) begin
            x_q   <= XW'(xlo_c);
            xlo_q <= XW'(xlo_c);
            xhi_q <= XW'(xhi_c);
            y_q   <= ylo_c;
            yhi_q <= yhi_c;
         end else if (xfer_c) begin
            if (row_end_c) begin
               x_q <= xlo_q;
               y_q <= y_q + HEIGHT_BITS'(1);
            end else begin
               x_q <= x_q + XW'(LANES);
            end
         end
      end
   end

   always_comb begin
      valid_o     = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      last_o      = 1'b0;
      lane_mask_o = '0;
      x_o         = x_q[WIDTH_BITS-1:0];
      y_o         = y_q;
      color_o     = color_q;
      case (state_q)
         S_SETUP: busy_o = 1'b1;
         S_RUN: begin
            valid_o = 1'b1;
            busy_o  = 1'b1;
            last_o  = last_c;
            for (int i = 0; i < int'(LANES); i++)
               lane_mask_o[i] = (x_q + XW'(i)) <= xhi_q;
         end
         S_DONE:  done_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gpu_fill_rect_stream.sv
// Directed bench for gpu_fill_rect_stream: a reference raster model fills a
// beat queue at each start; DUT beats are popped and compared on transfer.
module tb_gpu_fill_rect_stream;

   localparam int LANES = 4;

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic [3:0] mask;
      logic       last;
   } beat_t;

   logic        tb_clk = 1'b0;
   logic        n_rst;
   logic        start_i, abort_i, ready_i;
   logic [9:0]  x1_i, x2_i, clip_x0_i, clip_x1_i;
   logic [8:0]  y1_i, y2_i, clip_y0_i, clip_y1_i;
   logic [23:0] color_i;
   logic        valid_o, last_o, busy_o, done_o;
   logic [9:0]  x_o;
   logic [8:0]  y_o;
   logic [3:0]  lane_mask_o;
   logic [23:0] color_o;

   int          tests = 0;
   int          fails = 0;
   beat_t       sb[$];
   logic [23:0] cur_color;

   gpu_fill_rect_stream #(
      .WIDTH_BITS(10), .HEIGHT_BITS(9), .COLOR_BITS(24), .LANES(LANES)
   ) dut (
      .clk(tb_clk), .n_rst(n_rst), .start_i(start_i), .abort_i(abort_i),
      .x1_i(x1_i), .y1_i(y1_i), .x2_i(x2_i), .y2_i(y2_i), .color_i(color_i),
      .clip_x0_i(clip_x0_i), .clip_x1_i(clip_x1_i),
      .clip_y0_i(clip_y0_i), .clip_y1_i(clip_y1_i),
      .ready_i(ready_i), .valid_o(valid_o), .x_o(x_o), .y_o(y_o),
      .lane_mask_o(lane_mask_o), .color_o(color_o), .last_o(last_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 tb_clk = ~tb_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   // Reference raster: ordered corners, clipped, row-major LANES-wide beats
   task automatic push_fill(input int ax, input int ay, input int bx, input int by,
                            input int cx0, input int cx1, input int cy0, input int cy1);
      int xlo, xhi, ylo, yhi;
      beat_t b;
      xlo = (ax < bx) ? ax : bx;
      xhi = (ax < bx) ? bx : ax;
      ylo = (ay < by) ? ay : by;
      yhi = (ay < by) ? by : ay;
      if (cx0 > xlo) xlo = cx0;
      if (cx1 < xhi) xhi = cx1;
      if (cy0 > ylo) ylo = cy0;
      if (cy1 < yhi) yhi = cy1;
      for (int y = ylo; y <= yhi; y++) begin
         for (int x = xlo; x <= xhi; x += LANES) begin
            b.x  = 10'(x);
            b.y  = 9'(y);
            for (int i = 0; i < LANES; i++) b.mask[i] = (x + i <= xhi);
            b.last = (y == yhi) && (x + LANES > xhi);
            sb.push_back(b);
         end
      end
   endtask

   // Starts at posedge+1 of idle; returns at posedge+1 of cycle N+2
   task automatic start_fill(input int ax, input int ay, input int bx, input int by,
                             input int cx0, input int cx1, input int cy0, input int cy1,
                             input logic [23:0] col, input string tag);
      x1_i = 10'(ax); y1_i = 9'(ay); x2_i = 10'(bx); y2_i = 9'(by);
      clip_x0_i = 10'(cx0); clip_x1_i = 10'(cx1);
      clip_y0_i = 9'(cy0); clip_y1_i = 9'(cy1);
      color_i = col;
      cur_color = col;
      push_fill(ax, ay, bx, by, cx0, cx1, cy0, cy1);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      x1_i = 10'($urandom); x2_i = 10'($urandom); y1_i = 9'($urandom); y2_i = 9'($urandom);
      clip_x0_i = 10'($urandom); clip_x1_i = 10'($urandom);
      clip_y0_i = 9'($urandom); clip_y1_i = 9'($urandom);
      color_i = 24'($urandom);
      @(negedge tb_clk);
      chk({tag, "_setup_busy"}, 32'(busy_o), 32'd1);
      chk({tag, "_setup_valid"}, 32'(valid_o), 32'd0);
      tick();
   endtask

   task automatic check_beat(input string tag);
      beat_t b;
      if (sb.size() == 0) begin
         chk({tag, "_extra_beat"}, 32'(valid_o), 32'd0);
      end else begin
         b = sb.pop_front();
         chk({tag, "_x"}, 32'(x_o), 32'(b.x));
         chk({tag, "_y"}, 32'(y_o), 32'(b.y));
         chk({tag, "_mask"}, 32'(lane_mask_o), 32'(b.mask));
         chk({tag, "_last"}, 32'(last_o), 32'(b.last));
         chk({tag, "_color"}, 32'(color_o), 32'(cur_color));
      end
   endtask

   task automatic run_stream(input bit toggle, input int n_exp, input string tag);
      bit    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int    cyc = 0;
      int    xfers = 0;
      bit    stalled = 1'b0;
      bit    last_xfer = 1'b0;
      bit    seen_done = 1'b0;
      logic [47:0] held;
      while (cyc < 200 && !seen_done) begin
         ready_i = toggle ? pat[cyc % 4] : 1'b1;
         @(negedge tb_clk);
         if (cyc == 0) chk({tag, "_first_valid"}, 32'(valid_o), 32'd1);
         if (last_xfer) begin
            chk({tag, "_done_after_last"}, 32'(done_o), 32'd1);
            chk({tag, "_valid_after_last"}, 32'(valid_o), 32'd0);
            chk({tag, "_busy_in_done"}, 32'(busy_o), 32'd0);
            seen_done = 1'b1;
         end else if (valid_o) begin
            if (stalled)
               chk({tag, "_stall_hold"}, 32'({x_o, y_o, lane_mask_o, last_o, color_o} == held), 32'd1);
            if (ready_i) begin
               check_beat(tag);
               xfers++;
               stalled = 1'b0;
               if (last_o) last_xfer = 1'b1;
            end else begin
               stalled = 1'b1;
               held = {x_o, y_o, lane_mask_o, last_o, color_o};
            end
         end else begin
            chk({tag, "_early_done"}, 32'(done_o), 32'd0);
         end
         tick();
         cyc++;
      end
      chk({tag, "_reached_done"}, 32'(seen_done), 32'd1);
      chk({tag, "_transfers"}, 32'(xfers), 32'(n_exp));
      chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
      @(negedge tb_clk);
      chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
      sb.delete();
      ready_i = 1'b1;
      tick();
   endtask

   initial begin
      n_rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1;
      x1_i = '0; y1_i = '0; x2_i = '0; y2_i = '0; color_i = '0;
      clip_x0_i = '0; clip_x1_i = '0; clip_y0_i = '0; clip_y1_i = '0;
      cur_color = '0;
      tick();
      tick();
      @(negedge tb_clk);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_pixel", 32'({x_o, y_o, lane_mask_o, last_o}), 32'd0);
      chk("rst_color", 32'(color_o), 32'd0);
      tick();
      n_rst = 1'b1;
      tick();

      // Basic fill, then swapped corners, then clipped single beat
      start_fill(0, 0, 5, 6, 0, 1023, 0, 511, 24'hA1B2C3, "s1");
      run_stream(1'b0, 14, "s1");
      start_fill(5, 6, 0, 0, 0, 1023, 0, 511, 24'h123456, "s2");
      run_stream(1'b0, 14, "s2");
      start_fill(2, 1, 9, 3, 4, 6, 2, 2, 24'h00FF00, "s3");
      run_stream(1'b0, 1, "s3");

      // Fully clipped away: done two cycles after the start edge
      start_fill(20, 0, 30, 5, 0, 10, 0, 511, 24'h777777, "s4");
      @(negedge tb_clk);
      chk("s4_done", 32'(done_o), 32'd1);
      chk("s4_valid", 32'(valid_o), 32'd0);
      chk("s4_busy", 32'(busy_o), 32'd0);
      chk("s4_no_beats", 32'(sb.size()), 32'd0);
      tick();
      @(negedge tb_clk);
      chk("s4_done_drop", 32'(done_o), 32'd0);
      tick();

      start_fill(0, 0, 5, 6, 0, 1023, 0, 511, 24'hBEEF01, "s5");
      run_stream(1'b1, 14, "s5");

      // Abort on third beat, with an ignored start during RUN before it
      start_fill(0, 0, 5, 6, 0, 1023, 0, 511, 24'h0F0F0F, "s6");
      @(negedge tb_clk);
      check_beat("s6_b1");
      tick();
      start_i = 1'b1;
      x1_i = 10'd100; x2_i = 10'd200; y1_i = 9'd100; y2_i = 9'd200;
      clip_x0_i = 10'd0; clip_x1_i = 10'd1023; clip_y0_i = 9'd0; clip_y1_i = 9'd511;
      @(negedge tb_clk);
      check_beat("s6_b2");
      tick();
      start_i = 1'b0;
      abort_i = 1'b1;
      @(negedge tb_clk);
      check_beat("s6_b3");
      tick();
      abort_i = 1'b0;
      @(negedge tb_clk);
      chk("s6_abort_valid", 32'(valid_o), 32'd0);
      chk("s6_abort_busy", 32'(busy_o), 32'd0);
      chk("s6_abort_last", 32'(last_o), 32'd0);
      chk("s6_abort_done", 32'(done_o), 32'd0);
      tick();
      @(negedge tb_clk);
      chk("s6_start_ignored", 32'(busy_o), 32'd0);
      chk("s6_no_done", 32'(done_o), 32'd0);
      sb.delete();
      tick();
      start_fill(2, 1, 9, 3, 4, 6, 2, 2, 24'h314159, "s6r");
      run_stream(1'b0, 1, "s6r");

      // Reset in the middle of a fill
      start_fill(0, 0, 5, 6, 0, 1023, 0, 511, 24'hCAFE00, "s7");
      tick();
      tick();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      @(negedge tb_clk);
      chk("s7_rst_valid", 32'(valid_o), 32'd0);
      chk("s7_rst_busy", 32'(busy_o), 32'd0);
      chk("s7_rst_done", 32'(done_o), 32'd0);
      chk("s7_rst_pixel", 32'({x_o, y_o, lane_mask_o, last_o}), 32'd0);
      chk("s7_rst_color", 32'(color_o), 32'd0);
      sb.delete();
      tick();
      @(negedge tb_clk);
      chk("s7_post_done", 32'(done_o), 32'd0);
      chk("s7_post_busy", 32'(busy_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
